// File: rtl/imem_loader.sv
// Byte-stream program loader: zero-fills instruction memory, writes little-endian words
// assembled from a valid/ready byte stream, then raises the CPU start signal.
module imem_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_req_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    input  logic              byte_last_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              start_o,
    output logic              busy_o,
    output logic [ADDR_W:0]   word_cnt_o,
    output logic              err_o
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(MAX_WORDS - 1);
    localparam logic [ADDR_W:0]   MaxCnt   = (ADDR_W + 1)'(MAX_WORDS);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRecv,
        StWrite,
        StDone,
        StErr
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [31:0]         word_buf_q, word_buf_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                last_seen_q, last_seen_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic                err_q, err_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]         imem_data_q, imem_data_d;

    logic                accept;
    logic [31:0]         merged_buf;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            byte_idx_q  <= '0;
            word_buf_q  <= '0;
            addr_q      <= '0;
            last_seen_q <= 1'b0;
            word_cnt_q  <= '0;
            err_q       <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            we_q        <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            word_buf_q  <= word_buf_d;
            addr_q      <= addr_d;
            last_seen_q <= last_seen_d;
            word_cnt_q  <= word_cnt_d;
            err_q       <= err_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
        end
    end

    // ready_q is high exactly while in StRecv, so it qualifies the handshake directly.
    assign accept = byte_valid_i && ready_q;

    always_comb begin
        merged_buf = word_buf_q;
        merged_buf[{byte_idx_q, 3'b000} +: 8] = byte_data_i;
    end

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        word_buf_d  = word_buf_q;
        addr_d      = addr_q;
        last_seen_d = last_seen_q;
        word_cnt_d  = word_cnt_q;
        err_d       = err_q;
        start_d     = start_q;
        busy_d      = busy_q;
        ready_d     = 1'b0;
        we_d        = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (load_req_i) begin
                    state_d     = StClear;
                    busy_d      = 1'b1;
                    start_d     = 1'b0;
                    err_d       = 1'b0;
                    word_cnt_d  = '0;
                    addr_d      = '0;
                    byte_idx_d  = '0;
                    word_buf_d  = '0;
                    last_seen_d = 1'b0;
                    we_d        = 1'b1;
                    imem_addr_d = '0;
                    imem_data_d = '0;
                end
            end

            // addr_q tracks the address currently presented on the write port.
            StClear: begin
                if (addr_q == LastAddr) begin
                    state_d = StRecv;
                    addr_d  = '0;
                    ready_d = 1'b1;
                end else begin
                    addr_d      = addr_q + 1'b1;
                    we_d        = 1'b1;
                    imem_addr_d = addr_q + 1'b1;
                    imem_data_d = '0;
                end
            end

            StRecv: begin
                ready_d = 1'b1;
                if (accept) begin
                    if (word_cnt_q == MaxCnt) begin
                        // Memory already full: drop the byte and park in the error state.
                        state_d = StErr;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        start_d = 1'b0;
                        ready_d = 1'b0;
                    end else begin
                        word_buf_d = merged_buf;
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3 || byte_last_i) begin
                            state_d     = StWrite;
                            ready_d     = 1'b0;
                            we_d        = 1'b1;
                            imem_addr_d = addr_q;
                            imem_data_d = merged_buf;
                            last_seen_d = byte_last_i;
                            if (byte_last_i && byte_idx_q != 2'd3) begin
                                err_d = 1'b1;
                            end
                        end
                    end
                end
            end

            StWrite: begin
                addr_d     = addr_q + 1'b1;
                word_buf_d = '0;
                byte_idx_d = '0;
                if (word_cnt_q != MaxCnt) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
                if (last_seen_q) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    start_d = 1'b1;
                end else begin
                    state_d = StRecv;
                    ready_d = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign byte_ready_o = ready_q;
    assign imem_we_o    = we_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_data_o  = imem_data_q;
    assign start_o      = start_q;
    assign busy_o       = busy_q;
    assign word_cnt_o   = word_cnt_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a full-size instance for load/clear/reset checks and a
// four-word instance for the overflow path.
module tb_imem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        load_req, bvalid, blast;
    logic [7:0]  bdata;
    logic        ready, we, start, busy, err;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [8:0]  wcnt;

    logic        s_load, s_valid, s_last;
    logic [7:0]  s_bdata;
    logic        s_ready, s_we, s_start, s_busy, s_err;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_wcnt;

    imem_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
        .clk_i(clk), .rst_i(rst_n), .load_req_i(load_req), .byte_valid_i(bvalid),
        .byte_data_i(bdata), .byte_last_i(blast), .byte_ready_o(ready), .imem_we_o(we),
        .imem_addr_o(addr), .imem_data_o(wdata), .start_o(start), .busy_o(busy),
        .word_cnt_o(wcnt), .err_o(err)
    );

    imem_loader #(.ADDR_W(2), .MAX_WORDS(4)) dut_small (
        .clk_i(clk), .rst_i(rst_n), .load_req_i(s_load), .byte_valid_i(s_valid),
        .byte_data_i(s_bdata), .byte_last_i(s_last), .byte_ready_o(s_ready), .imem_we_o(s_we),
        .imem_addr_o(s_addr), .imem_data_o(s_wdata), .start_o(s_start), .busy_o(s_busy),
        .word_cnt_o(s_wcnt), .err_o(s_err)
    );

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         sb[$];
    logic [31:0] mem [256];
    logic [31:0] mdl_word;
    int          mdl_lane;
    int          mdl_addr;
    int          n_checks = 0;
    int          n_err = 0;
    int          s_writes = 0;
    logic [7:0]  prog [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Every write on the big instance must match the head of the scoreboard.
    always @(negedge clk) begin
        if (we) begin
            wr_t e;
            check("wr_ready_low", 32'(ready), 32'd0);
            if (sb.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(addr), 32'(e.a));
                check("wr_data", wdata, e.d);
            end
            mem[addr] = wdata;
        end
    end

    always @(negedge clk) begin
        if (s_we) s_writes++;
    end

    task automatic load_session();
        int n;
        int bad;
        wr_t w;
        @(posedge clk); #1;
        load_req = 1'b1;
        for (int i = 0; i < 256; i++) begin
            w.a = 8'(i);
            w.d = 32'd0;
            sb.push_back(w);
        end
        mdl_addr = 0;
        mdl_lane = 0;
        mdl_word = '0;
        @(posedge clk); #1;
        load_req = 1'b0;
        n = 0;
        bad = 0;
        for (int k = 0; k < 400; k++) begin
            if (!we) break;
            n++;
            if (!busy || start || ready) bad++;
            @(posedge clk); #1;
        end
        check("clear_len", 32'(n), 32'd256);
        check("clear_flags", 32'(bad), 32'd0);
        check("recv_ready", 32'(ready), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l, input int gap);
        int k;
        wr_t w;
        bvalid = 1'b1;
        bdata  = b;
        blast  = l;
        for (k = 0; k < 50; k++) begin
            logic rdy;
            rdy = ready;
            @(posedge clk); #1;
            if (rdy) break;
        end
        if (k == 50) check("hs_timeout", 32'd1, 32'd0);
        mdl_word[mdl_lane*8 +: 8] = b;
        if (mdl_lane == 3 || l) begin
            w.a = 8'(mdl_addr);
            w.d = mdl_word;
            sb.push_back(w);
            mdl_addr++;
            mdl_lane = 0;
            mdl_word = '0;
        end else begin
            mdl_lane++;
        end
        if (gap > 0) begin
            bvalid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic s_send(input logic [7:0] b);
        int k;
        s_valid = 1'b1;
        s_bdata = b;
        for (k = 0; k < 50; k++) begin
            logic rdy;
            rdy = s_ready;
            @(posedge clk); #1;
            if (rdy) break;
        end
        if (k == 50) check("s_hs_timeout", 32'd1, 32'd0);
    endtask

    task automatic send_prog(input int maxgap);
        for (int i = 0; i < 8; i++) begin
            send_byte(prog[i], i == 7, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
        bvalid = 1'b0;
        blast  = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        check("done_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        prog = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        rst_n = 1'b0;
        load_req = 1'b0; bvalid = 1'b0; blast = 1'b0; bdata = '0;
        s_load = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_bdata = '0;
        #12;
        check("rst_we", 32'(we), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wcnt", 32'(wcnt), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_data", wdata, 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_s_wcnt", 32'(s_wcnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Clear phase then a two-word program, back-to-back bytes.
        load_session();
        send_prog(0);
        wait_idle();
        check("p1_mem0", mem[0], 32'h0050_0513);
        check("p1_mem1", mem[1], 32'h0010_0593);
        check("p1_wcnt", 32'(wcnt), 32'd2);
        check("p1_start", 32'(start), 32'd1);
        check("p1_err", 32'(err), 32'd0);
        check("p1_sb_empty", 32'(sb.size()), 32'd0);

        // Reload from DONE with random valid gaps.
        load_session();
        send_prog(2);
        wait_idle();
        check("p2_mem0", mem[0], 32'h0050_0513);
        check("p2_mem1", mem[1], 32'h0010_0593);
        check("p2_wcnt", 32'(wcnt), 32'd2);
        check("p2_sb_empty", 32'(sb.size()), 32'd0);

        // Partial final word.
        load_session();
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'hBB, 1'b1, 0);
        bvalid = 1'b0;
        blast  = 1'b0;
        wait_idle();
        check("part_mem0", mem[0], 32'h0000_BBAA);
        check("part_err", 32'(err), 32'd1);
        check("part_start", 32'(start), 32'd1);
        check("part_wcnt", 32'(wcnt), 32'd1);

        // Reset in the middle of the third word.
        load_session();
        for (int i = 0; i < 8; i++) send_byte(prog[i], 1'b0, 0);
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h22, 1'b0, 0);
        bvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", 32'(we), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_wcnt", 32'(wcnt), 32'd0);
        check("mid_rst_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        load_session();

        // Overflow on the four-word instance.
        @(posedge clk); #1;
        s_load = 1'b1;
        @(posedge clk); #1;
        s_load = 1'b0;
        base = 0;
        for (int k = 0; k < 20; k++) begin
            if (s_ready) break;
            if (s_we) base++;
            @(posedge clk); #1;
        end
        check("s_clear_len", 32'(base), 32'd4);
        base = s_writes;
        for (int i = 0; i < 17; i++) s_send(8'(i + 1));
        s_valid = 1'b0;
        check("ovf_ready", 32'(s_ready), 32'd0);
        check("ovf_err", 32'(s_err), 32'd1);
        check("ovf_start", 32'(s_start), 32'd0);
        check("ovf_busy", 32'(s_busy), 32'd0);
        check("ovf_wcnt", 32'(s_wcnt), 32'd4);
        repeat (3) @(posedge clk);
        #1;
        check("ovf_writes", 32'(s_writes - base), 32'd4);
        check("ovf_err_hold", 32'(s_err), 32'd1);

        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader for the pipelined CPU's instruction memory.
- Receives program bytes over a valid/ready handshake and assembles them little-endian into 32-bit words.
- Zero-fills instruction memory, writes the words, then raises the CPU start signal.
- Replaces bench-side program preload and Start driving in hardware/FPGA builds; sits between the host link and the Instruction_Memory write port.

Parameters:
ADDR_W, 8, word-address width of instruction memory
MAX_WORDS, 256, instruction memory depth in words; at most 2^ADDR_W

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-low
load_req_i  input  1  one-cycle pulse that begins a load session
byte_valid_i  input  1  byte_data_i is valid
byte_data_i  input  8  program byte
byte_last_i  input  1  qualifies the current byte as the final byte of the program
byte_ready_o  output  1  loader accepts a byte this cycle
imem_we_o  output  1  instruction memory write strobe
imem_addr_o  output  ADDR_W  word address
imem_data_o  output  32  write data
start_o  output  1  CPU start; drives the CPU start_i input
busy_o  output  1  high from load request until DONE or ERR
word_cnt_o  output  ADDR_W+1  words written this session, excluding the clear phase
err_o  output  1  sticky error flag

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State returns to IDLE.
  - All outputs are 0, and the byte index, word buffer and address are cleared.
  - Reset in any state, including mid-word or mid-clear, aborts the session. No partial write is issued.
- Handshake:
  - A byte transfers on a rising edge where byte_valid_i and byte_ready_o are both 1.
  - byte_ready_o is high only in RECV.
  - Data and valid from the sender must hold until the transfer.
- IDLE:
  - Outputs are quiet, except start_o, which keeps its previous value.
  - A load_req_i pulse sets busy_o=1, clears start_o, err_o and word_cnt_o, sets addr=0, and moves to CLEAR.
- CLEAR:
  - imem_we_o=1 with imem_data_o=0, imem_addr_o incrementing 0..MAX_WORDS-1, one word per cycle.
  - Takes exactly MAX_WORDS cycles, then goes to RECV with addr=0.
- RECV:
  - Each accepted byte goes into buffer lane byte_idx (lane 0 = bits 7:0) and increments byte_idx (2 bits).
  - On acceptance of lane 3, or of any lane with byte_last_i=1, go to WRITE. Unfilled lanes stay 0.
  - Accepting a byte with byte_last_i=1 and byte_idx!=3 sets err_o (partial final word). The padded word is still written.
  - Accepting a byte while word_cnt_o==MAX_WORDS sets err_o, discards the byte, and goes to ERR.
- WRITE (exactly one cycle):
  - imem_we_o=1, imem_addr_o=addr, imem_data_o=buffer, byte_ready_o=0.
  - Next edge: addr++, word_cnt_o++, buffer and byte_idx cleared.
  - Goes to DONE if the last byte was seen, else RECV.
  - Latency: a byte accepted at edge N produces imem_we_o high in the cycle after edge N, written at edge N+1.
  - Peak throughput: 4 bytes per 5 cycles.
- DONE:
  - busy_o=0, start_o=1, held until reset or a new load_req_i.
  - load_req_i in DONE drops start_o the next cycle and re-enters CLEAR.
- ERR:
  - busy_o=0, start_o=0, err_o=1, byte_ready_o=0.
  - Left only by reset or load_req_i, which starts a new session.
- load_req_i during CLEAR, RECV or WRITE is ignored.
- imem_addr_o and imem_data_o hold their last values when imem_we_o=0. Only imem_we_o is significant.
- word_cnt_o saturates at MAX_WORDS.
- All outputs are registered.

Test Plan:
- Reset, then load_req_i with MAX_WORDS=256:
  - imem_we_o is high for exactly 256 cycles, data 0, addresses 0..255.
  - busy_o=1 throughout; start_o=0.
- Stream 0x13,0x05,0x50,0x00, then 0x93,0x05,0x10,0x00 with last on the final byte:
  - addr0=0x00500513 and addr1=0x00100593.
  - word_cnt_o=2, start_o=1, err_o=0, busy_o=0.
- Same stream with random byte_valid_i gaps, and with valid held across WRITE cycles:
  - Identical memory contents.
  - No byte is lost or duplicated.
  - byte_ready_o=0 in every WRITE cycle.
- Partial word, 0xAA,0xBB with last:
  - addr0=0x0000BBAA, err_o=1, start_o=1, word_cnt_o=1.
- Overflow, with MAX_WORDS=4:
  - After 16 bytes without last, the 17th valid byte is not written.
  - State is ERR with err_o=1, start_o=0, byte_ready_o=0, word_cnt_o=4.
- Reset asserted after 2 bytes of word 3:
  - No write occurs for that word, and all outputs are 0 immediately.
  - A fresh load_req_i restarts CLEAR from addr 0.
